// File: rtl/csr_unit_if.sv
// rtl/csr_unit_if.sv - CSR access bus between the EX stage and csr_unit
//
// Purpose : carries one CSR instruction's access from the decoder/EX stage
//           into the CSR register file and returns the pre-write value.
// Signals : csr_read  - CSR instruction present in EX
//           csr_write - write request
//           csr_op    - 00 NOP, 01 ASSIGN, 10 SET, 11 CLEAR
//           csr_addr  - 12-bit CSR address
//           csr_src   - rs1 value or zero-extended uimm
//           csr_rdata - old CSR value (combinational, 0 when csr_read=0)
interface csr_unit_if #(
  parameter int XLEN = 32
);
  logic            csr_read;
  logic            csr_write;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_src;
  logic [XLEN-1:0] csr_rdata;

  modport master (
    output csr_read,
    output csr_write,
    output csr_op,
    output csr_addr,
    output csr_src,
    input  csr_rdata
  );

  modport slave (
    input  csr_read,
    input  csr_write,
    input  csr_op,
    input  csr_addr,
    input  csr_src,
    output csr_rdata
  );
endinterface

// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - machine-mode CSR file, counters and trap/WFI sequencer
//
// Purpose : machine-mode CSRs (mstatus, mie, mtvec, mepc, mip), 64-bit-capable
//           mcycle/minstret counters, interrupt entry, mret return and a
//           RUN/SLEEP wait-for-interrupt FSM that redirects the PC.
// Ports   : clk, rst_n          - clock, asynchronous active-low reset
//           bus (slave)         - CSR access bus (see csr_unit_if)
//           stall               - blocks CSR writes, retire counting, trap/mret/wfi
//           retire              - one instruction retired this cycle
//           mret, wfi           - mret / wfi instruction in EX
//           pc_in               - PC saved into mepc on trap entry
//           ext_irq, timer_irq  - level interrupt requests
//           trap_valid, trap_pc - registered one-cycle PC redirect
//           wfi_stall           - registered pipeline hold while sleeping
module csr_unit #(
  parameter int              XLEN        = 32,
  parameter int              CNT_WIDTH   = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  csr_unit_if.slave       bus,
  input  logic            stall,
  input  logic            retire,
  input  logic            mret,
  input  logic            wfi,
  input  logic [XLEN-1:0] pc_in,
  input  logic            ext_irq,
  input  logic            timer_irq,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_pc,
  output logic            wfi_stall
);

  localparam int HI_W = CNT_WIDTH - 32;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;

  typedef enum logic {S_RUN, S_SLEEP} state_t;

  state_t                 state_q, state_d;
  logic                   st_mie_q, st_mie_d;
  logic                   st_mpie_q, st_mpie_d;
  logic                   mtie_q, mtie_d;
  logic                   meie_q, meie_d;
  logic [XLEN-3:0]        mtvec_q, mtvec_d;
  logic [XLEN-3:0]        mepc_q, mepc_d;
  logic [CNT_WIDTH-1:0]   mcycle_q, mcycle_d;
  logic [CNT_WIDTH-1:0]   minstret_q, minstret_d;
  logic                   trap_valid_q, trap_valid_d;
  logic [XLEN-1:0]        trap_pc_q, trap_pc_d;
  logic                   wfi_stall_q, wfi_stall_d;

  logic [XLEN-1:0]        csr_old;
  logic [XLEN-1:0]        wdata;
  logic                   we;
  logic                   pend;
  logic                   take;
  logic                   do_mret;
  logic                   enter_trap;
  logic [63:0]            mcycle_ext;
  logic [63:0]            minstret_ext;
  logic                   unused_ok;

  // Word-aligned registers never store the low two PC bits.
  assign unused_ok = &{1'b0, pc_in[1:0]};

  assign mcycle_ext   = 64'(mcycle_q);
  assign minstret_ext = 64'(minstret_q);

  // Old value of the addressed CSR, also the operand for SET/CLEAR.
  always_comb begin
    csr_old = '0;
    case (bus.csr_addr)
      A_MSTATUS: begin
        csr_old[12:11] = 2'b11;
        csr_old[7]     = st_mpie_q;
        csr_old[3]     = st_mie_q;
      end
      A_MIE: begin
        csr_old[11] = meie_q;
        csr_old[7]  = mtie_q;
      end
      A_MTVEC:                 csr_old = {mtvec_q, 2'b00};
      A_MEPC:                  csr_old = {mepc_q, 2'b00};
      A_MIP: begin
        csr_old[11] = ext_irq;
        csr_old[7]  = timer_irq;
      end
      A_MCYCLE,   A_CYCLE:     csr_old = mcycle_ext[31:0];
      A_MCYCLEH,  A_CYCLEH:    csr_old = mcycle_ext[63:32];
      A_MINSTRET, A_INSTRET:   csr_old = minstret_ext[31:0];
      A_MINSTRETH, A_INSTRETH: csr_old = minstret_ext[63:32];
      default:                 csr_old = '0;
    endcase
  end

  assign bus.csr_rdata = bus.csr_read ? csr_old : '0;

  always_comb begin
    case (bus.csr_op)
      2'b01:   wdata = bus.csr_src;
      2'b10:   wdata = csr_old | bus.csr_src;
      2'b11:   wdata = csr_old & ~bus.csr_src;
      default: wdata = csr_old;
    endcase
  end

  assign we   = bus.csr_write && !stall && (bus.csr_op != 2'b00);
  assign pend = (meie_q && ext_irq) || (mtie_q && timer_irq);
  assign take = st_mie_q && pend && !stall;

  // mret wins over a simultaneous interrupt; the interrupt is re-evaluated
  // next cycle with the restored MIE. In SLEEP the stall input is ignored.
  assign do_mret    = (state_q == S_RUN) && mret && !stall;
  assign enter_trap = ((state_q == S_RUN) && !do_mret && take) ||
                      ((state_q == S_SLEEP) && pend && st_mie_q);

  always_comb begin
    state_d      = state_q;
    st_mie_d     = st_mie_q;
    st_mpie_d    = st_mpie_q;
    mtie_d       = mtie_q;
    meie_d       = meie_q;
    mtvec_d      = mtvec_q;
    mepc_d       = mepc_q;
    mcycle_d     = mcycle_q + 1'b1;
    minstret_d   = minstret_q + {{(CNT_WIDTH-1){1'b0}}, (retire && !stall)};
    trap_valid_d = 1'b0;
    trap_pc_d    = trap_pc_q;
    wfi_stall_d  = wfi_stall_q;

    // Software writes first; a write to either counter half replaces that
    // half and drops this cycle's increment.
    if (we) begin
      case (bus.csr_addr)
        A_MSTATUS: begin
          st_mie_d  = wdata[3];
          st_mpie_d = wdata[7];
        end
        A_MIE: begin
          mtie_d = wdata[7];
          meie_d = wdata[11];
        end
        A_MTVEC:     mtvec_d    = wdata[XLEN-1:2];
        A_MEPC:      mepc_d     = wdata[XLEN-1:2];
        A_MCYCLE:    mcycle_d   = {mcycle_q[CNT_WIDTH-1:32], wdata[31:0]};
        A_MCYCLEH:   mcycle_d   = {wdata[HI_W-1:0], mcycle_q[31:0]};
        A_MINSTRET:  minstret_d = {minstret_q[CNT_WIDTH-1:32], wdata[31:0]};
        A_MINSTRETH: minstret_d = {wdata[HI_W-1:0], minstret_q[31:0]};
        default: ;
      endcase
    end

    // Trap/return sequencing last so it overrides a same-cycle CSR write.
    if (do_mret) begin
      st_mie_d     = st_mpie_q;
      st_mpie_d    = 1'b1;
      trap_valid_d = 1'b1;
      trap_pc_d    = {mepc_q, 2'b00};
    end else if (enter_trap) begin
      mepc_d       = pc_in[XLEN-1:2];
      st_mpie_d    = st_mie_q;
      st_mie_d     = 1'b0;
      trap_valid_d = 1'b1;
      trap_pc_d    = {mtvec_q, 2'b00};
    end

    case (state_q)
      S_RUN: begin
        if (!do_mret && wfi && !stall && !pend) begin
          state_d     = S_SLEEP;
          wfi_stall_d = 1'b1;
        end
      end
      S_SLEEP: begin
        if (pend) begin
          state_d     = S_RUN;
          wfi_stall_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_RUN;
        wfi_stall_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      st_mie_q     <= 1'b0;
      st_mpie_q    <= 1'b0;
      mtie_q       <= 1'b0;
      meie_q       <= 1'b0;
      mtvec_q      <= MTVEC_RESET[XLEN-1:2];
      mepc_q       <= '0;
      mcycle_q     <= '0;
      minstret_q   <= '0;
      trap_valid_q <= 1'b0;
      trap_pc_q    <= '0;
      wfi_stall_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      st_mie_q     <= st_mie_d;
      st_mpie_q    <= st_mpie_d;
      mtie_q       <= mtie_d;
      meie_q       <= meie_d;
      mtvec_q      <= mtvec_d;
      mepc_q       <= mepc_d;
      mcycle_q     <= mcycle_d;
      minstret_q   <= minstret_d;
      trap_valid_q <= trap_valid_d;
      trap_pc_q    <= trap_pc_d;
      wfi_stall_q  <= wfi_stall_d;
    end
  end

  assign trap_valid = trap_valid_q;
  assign trap_pc    = trap_pc_q;
  assign wfi_stall  = wfi_stall_q;

endmodule

// File: tb/tb_csr_unit.sv
// tb/tb_csr_unit.sv - directed self-checking bench for csr_unit
module tb_csr_unit;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, retire, mret, wfi, ext_irq, timer_irq;
  logic [31:0] pc_in;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        wfi_stall;

  int n_cmp = 0;
  int n_err = 0;

  always #50 clk = ~clk;

  csr_unit_if #(.XLEN(32)) bus ();

  csr_unit #(
    .XLEN        (32),
    .CNT_WIDTH   (64),
    .MTVEC_RESET (MTVEC_RST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .stall      (stall),
    .retire     (retire),
    .mret       (mret),
    .wfi        (wfi),
    .pc_in      (pc_in),
    .ext_irq    (ext_irq),
    .timer_irq  (timer_irq),
    .trap_valid (trap_valid),
    .trap_pc    (trap_pc),
    .wfi_stall  (wfi_stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.csr_read = 1'b1;
    bus.csr_addr = a;
    #1;
    check(tag, 64'(bus.csr_rdata), 64'(exp));
    bus.csr_read = 1'b0;
  endtask

  task automatic csr_wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] src);
    bus.csr_write = 1'b1;
    bus.csr_op    = op;
    bus.csr_addr  = a;
    bus.csr_src   = src;
    tick();
    bus.csr_write = 1'b0;
    bus.csr_op    = 2'b00;
  endtask

  task automatic chk_trap(input string tag, input logic v, input logic [31:0] pc);
    check({tag, "_valid"}, 64'(trap_valid), 64'(v));
    if (v) check({tag, "_pc"}, 64'(trap_pc), 64'(pc));
  endtask

  initial begin
    bus.csr_read = 0; bus.csr_write = 0; bus.csr_op = 0; bus.csr_addr = 0; bus.csr_src = 0;
    stall = 0; retire = 0; mret = 0; wfi = 0; ext_irq = 0; timer_irq = 0; pc_in = 0;

    // Reset values
    #3;
    check("rst_trap_valid", 64'(trap_valid), 64'd0);
    check("rst_trap_pc", 64'(trap_pc), 64'd0);
    check("rst_wfi_stall", 64'(wfi_stall), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) tick();
    chk_csr("rst_mstatus", 12'h300, 32'h0000_1800);
    chk_csr("rst_mtvec", 12'h305, MTVEC_RST);
    chk_csr("rst_mie", 12'h304, 32'h0);
    chk_csr("mcycle_10", 12'hB00, 32'd10);
    chk_csr("cycle_alias_10", 12'hC00, 32'd10);
    chk_csr("mcycleh_0", 12'hB80, 32'd0);
    chk_csr("unmapped", 12'h123, 32'd0);

    // Setup and external interrupt entry
    csr_wr(2'b01, 12'h305, 32'h0000_0100);
    csr_wr(2'b10, 12'h300, 32'h0000_0008);
    csr_wr(2'b10, 12'h304, 32'h0000_0800);
    chk_csr("mtvec_w", 12'h305, 32'h0000_0100);
    chk_csr("mstatus_mie", 12'h300, 32'h0000_1808);
    chk_csr("mie_meie", 12'h304, 32'h0000_0800);
    pc_in = 32'h40; ext_irq = 1'b1;
    chk_csr("mip_meip", 12'h344, 32'h0000_0800);
    tick();
    ext_irq = 1'b0;
    chk_trap("irq_trap", 1'b1, 32'h100);
    chk_csr("irq_mepc", 12'h341, 32'h40);
    chk_csr("irq_mstatus", 12'h300, 32'h0000_1880);
    tick();
    chk_trap("irq_pulse_end", 1'b0, 32'h0);

    // mret, then mret together with a pending interrupt
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk_trap("mret", 1'b1, 32'h40);
    chk_csr("mret_mstatus", 12'h300, 32'h0000_1888);
    tick();
    chk_trap("mret_pulse_end", 1'b0, 32'h0);
    // mret from mstatus 0x1888 restores MIE=1 again
    mret = 1'b1; ext_irq = 1'b1; pc_in = 32'h80;
    tick();
    mret = 1'b0;
    chk_trap("mret_beats_irq", 1'b1, 32'h40);
    tick();
    ext_irq = 1'b0;
    chk_trap("irq_after_mret", 1'b1, 32'h100);
    chk_csr("irq2_mepc", 12'h341, 32'h80);
    chk_csr("irq2_mstatus", 12'h300, 32'h0000_1880);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk_trap("mret2", 1'b1, 32'h80);
    chk_csr("mret2_mstatus", 12'h300, 32'h0000_1888);

    // Counter carry and write suppression
    csr_wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    csr_wr(2'b01, 12'hB80, 32'h0);
    chk_csr("mcycle_wr_lo", 12'hB00, 32'hFFFF_FFFF);
    chk_csr("mcycle_wr_hi", 12'hB80, 32'h0);
    tick();
    chk_csr("mcycleh_carry", 12'hB80, 32'h1);
    chk_csr("mcycle_wrap", 12'hB00, 32'h0);
    chk_csr("cycleh_alias", 12'hC80, 32'h1);
    stall = 1'b1; retire = 1'b1;
    tick();
    stall = 1'b0;
    chk_csr("minstret_stalled", 12'hB02, 32'h0);
    repeat (3) tick();
    retire = 1'b0;
    chk_csr("minstret_3", 12'hB02, 32'h3);
    chk_csr("instret_alias", 12'hC02, 32'h3);
    retire = 1'b1;
    csr_wr(2'b01, 12'hB02, 32'h10);
    retire = 1'b0;
    chk_csr("minstret_wr", 12'hB02, 32'h10);
    stall = 1'b1;
    csr_wr(2'b01, 12'h305, 32'h999);
    stall = 1'b0;
    chk_csr("stalled_write", 12'h305, 32'h100);

    // WFI sleep and wake-up trap (stall is ignored while asleep)
    wfi = 1'b1;
    tick();
    wfi = 1'b0;
    stall = 1'b1;
    check("wfi_enter", 64'(wfi_stall), 64'd1);
    repeat (19) tick();
    check("wfi_hold_20", 64'(wfi_stall), 64'd1);
    check("wfi_no_trap", 64'(trap_valid), 64'd0);
    pc_in = 32'hC0; ext_irq = 1'b1;
    tick();
    ext_irq = 1'b0; stall = 1'b0;
    check("wfi_wake", 64'(wfi_stall), 64'd0);
    chk_trap("wfi_trap", 1'b1, 32'h100);
    chk_csr("wfi_mepc", 12'h341, 32'hC0);
    tick();
    chk_trap("wfi_pulse_end", 1'b0, 32'h0);
    // MIE now 0; wfi with an enabled pending irq is a NOP
    ext_irq = 1'b1; wfi = 1'b1;
    tick();
    wfi = 1'b0; ext_irq = 1'b0;
    check("wfi_pend_nop", 64'(wfi_stall), 64'd0);
    chk_trap("wfi_pend_notrap", 1'b0, 32'h0);

    // Read-only and alias writes
    timer_irq = 1'b1;
    bus.csr_read = 1'b1; bus.csr_write = 1'b1; bus.csr_op = 2'b11;
    bus.csr_addr = 12'h344; bus.csr_src = 32'hFFFF_FFFF;
    #1;
    check("mip_clear_rdata", 64'(bus.csr_rdata), 64'h80);
    tick();
    bus.csr_write = 1'b0; bus.csr_read = 1'b0;
    chk_csr("mip_after_clear", 12'h344, 32'h80);
    timer_irq = 1'b0;
    csr_wr(2'b01, 12'hB00, 32'h1000);
    bus.csr_read = 1'b1; bus.csr_write = 1'b1; bus.csr_op = 2'b01;
    bus.csr_addr = 12'hC00; bus.csr_src = 32'h0;
    #1;
    check("alias_wr_rdata", 64'(bus.csr_rdata), 64'h1000);
    tick();
    bus.csr_write = 1'b0; bus.csr_read = 1'b0; bus.csr_op = 2'b00;
    chk_csr("alias_wr_ignored", 12'hB00, 32'h1001);

    // Asynchronous reset during SLEEP
    wfi = 1'b1;
    tick();
    wfi = 1'b0;
    check("sleep_again", 64'(wfi_stall), 64'd1);
    #20 rst_n = 1'b0;
    #1;
    check("async_rst_wfi_stall", 64'(wfi_stall), 64'd0);
    check("async_rst_trap_valid", 64'(trap_valid), 64'd0);
    check("async_rst_trap_pc", 64'(trap_pc), 64'd0);
    chk_csr("async_rst_mtvec", 12'h305, MTVEC_RST);
    chk_csr("async_rst_mstatus", 12'h300, 32'h0000_1800);
    chk_csr("async_rst_mcycle", 12'hB00, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Machine-mode CSR register file and trap sequencer for the 5-stage RV32 core.
- Sits in EX beside the ALU. It consumes the decoder's csr_read/csr_write/csr_op/csr_rsrc outputs.
- Generalises CSR handling to parametrised counters, interrupt entry, mret return and a WFI sleep FSM.
- Drives PC redirect on trap/return.

Parameters:
- XLEN, 32, data width of CSR read/write path.
- CNT_WIDTH, 64, width of mcycle/minstret (legal 33..64; upper part readable via *h addresses).
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- csr_read  in  1  CSR instruction in EX.
- csr_write  in  1  CSR write request.
- csr_op  in  2  00 NOP, 01 ASSIGN, 10 SET(OR), 11 CLEAR(AND-NOT).
- csr_addr  in  12  CSR address (inst[31:20]).
- csr_src  in  XLEN  rs1 value, or zero-extended uimm (mux done upstream by csr_rsrc).
- csr_rdata  out  XLEN  old CSR value, combinational.
- stall  in  1  pipeline stall; suppresses all CSR writes, retire counting and trap/mret/wfi acceptance.
- retire  in  1  one instruction retired this cycle.
- mret  in  1  mret in EX.
- wfi  in  1  wfi in EX.
- pc_in  in  XLEN  PC to save into mepc on trap.
- ext_irq  in  1  level external interrupt.
- timer_irq  in  1  level timer interrupt.
- trap_valid  out  1  registered one-cycle redirect pulse.
- trap_pc  out  XLEN  registered redirect target.
- wfi_stall  out  1  registered; holds pipeline while sleeping.

Behaviour:
- Reset (async, rst_n=0):
  - mstatus.MIE=0, MPIE=0; mie=0; mepc=0; mtvec=MTIVEC_RESET; counters=0.
  - trap_valid=0, trap_pc=0, wfi_stall=0; FSM=RUN.
  - Reset mid-sleep or mid-trap aborts immediately.
- Address map (else read 0, write ignored):
  - mstatus 0x300: MIE[3], MPIE[7]; MPP[12:11] reads 2'b11; other bits read 0.
  - mie 0x304: MTIE[7], MEIE[11].
  - mtvec 0x305: bits[1:0] read 0.
  - mepc 0x341: bits[1:0] read 0.
  - mip 0x344: MTIP[7]=timer_irq, MEIP[11]=ext_irq; read-only.
  - mcycle 0xB00 / mcycleh 0xB80, minstret 0xB02 / minstreth 0xB82: writable.
  - 0xC00 / 0xC80 / 0xC02 / 0xC82: read-only aliases.
  - *h addresses read counter[CNT_WIDTH-1:32], zero-padded.
- csr_rdata is valid whenever csr_read=1, returning the pre-write value; otherwise 0.
- Write (csr_write && !stall && csr_op!=NOP), new value by op:
  - ASSIGN: src.
  - SET: old|src.
  - CLEAR: old&~src.
  - Only implemented bits change; writes to read-only/alias addresses are ignored.
- Counters:
  - mcycle increments every cycle; minstret increments when retire && !stall.
  - Wrap at 2^CNT_WIDTH to 0.
  - A software write to either half replaces that half and suppresses that cycle's increment.
- Interrupts:
  - pend = (MEIE&ext_irq) | (MTIE&timer_irq).
  - take = MIE & pend & !stall.
- FSM states RUN, SLEEP:
  - RUN, take (no mret): mepc<=pc_in, MPIE<=MIE, MIE<=0; next cycle trap_valid=1, trap_pc={mtvec[31:2],2'b00}.
  - RUN, mret && !stall: MIE<=MPIE, MPIE<=1; next cycle trap_valid=1, trap_pc=mepc. mret beats a simultaneous take; the interrupt is evaluated again next cycle.
  - RUN, wfi && !stall && !pend: go to SLEEP, wfi_stall<=1.
  - RUN, wfi && pend: acts as NOP.
  - SLEEP, pend: wfi_stall<=0, go to RUN. If MIE=1, take the trap on that same edge using pc_in. Stall is ignored in SLEEP.
  - SLEEP, !pend: remain in SLEEP.
- trap_valid is high for exactly one cycle per event; a CSR write and a trap in the same cycle apply the trap's mstatus update last.

Test Plan:
- Reset, then read 0x300, 0x305 and 0xB00 after 10 cycles: returns 0x1800, MTVEC_RESET, and 10 (±0 per defined count start).
- Write mtvec=0x100 with ASSIGN, SET 0x8 at 0x300, SET 0x800 at 0x304, raise ext_irq with pc_in=0x40: next cycle trap_valid=1, trap_pc=0x100; mepc reads 0x40, mstatus reads 0x1880.
- Issue mret: next cycle trap_pc=0x40; mstatus reads 0x1888. Asserting ext_irq together with mret delays the trap by exactly one cycle.
- Write mcycle=0xFFFF_FFFF, mcycleh=0: two cycles later mcycleh reads 1 and mcycle reads 0. Assert retire with stall=1: minstret unchanged.
- Issue wfi with MEIE=1, MIE=1, no irq: wfi_stall=1 for 20 cycles. Raise ext_irq: wfi_stall=0 and trap_valid pulses once to mtvec.
- Apply CLEAR 0xFFFF_FFFF at 0x344 and ASSIGN at 0xC00: rdata returns old value and no state changes. Assert rst_n low during SLEEP: all outputs are 0 asynchronously.
